mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the ALU in the execute stage and takes the same A/B operands from the register file. HI/LO feed the write-back mux for MFHI/MFLO alongside ALUResult; control stalls the PC while busy.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- in_start_1  in  1  one-cycle request; operands and op sampled on this edge
- in_op_3  in  3  MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101; others are no-ops
- A  in  32  multiplicand / dividend / MTHI-MTLO source
- B  in  32  multiplier / divisor
- out_busy_1  out  1  iteration in progress; new starts ignored
- out_done_1  out  1  one-cycle pulse; HI/LO hold the new result
- out_hi_32  out  32  HI register (product[63:32] / remainder)
- out_lo_32  out  32  LO register (product[31:0] / quotient)

## Operation
- Reset: state IDLE, HI=LO=0, busy=0, done=0, counter=0.
- FSM IDLE -> RUN -> FIX -> IDLE.
- IDLE with in_start_1 and op MULT..DIVU: latch |A|, |B| (signed ops) or A, B (unsigned ops), latch the result sign, counter=31, go RUN.
- IDLE with in_start_1 and MTHI/MTLO: write A to HI/LO at that edge, stay IDLE, no busy, no done.
- RUN, multiply: shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- RUN, divide: restoring shift-subtract, one quotient bit per cycle.
- RUN: counter decrements each cycle; at counter==0 go FIX.
- FIX: apply sign correction.
  - Product: negate the 64-bit result if the sign flag is set.
  - Quotient: negative if the operand signs differ.
  - Remainder: takes the sign of the dividend.
  - Write HI/LO, pulse done, go IDLE.
- Divide by zero: LO=32'hFFFF_FFFF, HI=A; full latency still taken.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0.
- in_start_1 while busy: ignored entirely, including MTHI/MTLO.
- Reset asserted mid-operation: immediately IDLE, HI/LO=0, no done pulse.
- Undefined op with start: ignored.

## Timing
- Start accepted at edge E0; busy high from after E0 through edge E33 (33 cycles).
- HI/LO updated at E33.
- done high for exactly the one cycle after E33, with busy already low.
- A new start is accepted in the done cycle (back-to-back).
- A/B may change after E0 without effect.
- MTHI/MTLO: one edge, visible the next cycle.
- HI/LO are stable between writes.

## Configuration
- MUL_DIV_SIGNED_EN defined: MULT/DIV do signed pre-abs and FIX-state sign correction as above.
- MUL_DIV_SIGNED_EN undefined:
  - MULT/DIV execute exactly as MULTU/DIVU (no sign logic synthesised).
  - The overflow special case is absent.
  - Latency is unchanged.

## Structure
- The shared package mul_div_pkg holds:
  - op encodings
  - FSM state enum (IDLE, RUN, FIX)
  - 5-bit iteration count constant (31)
  - divide-by-zero quotient constant
- One sub-module, mul_div_step: combinational single-iteration datapath (add-or-pass for multiply, trial subtract and quotient bit for divide) taking the current accumulator and returning the next one.
- The FSM, counter and HI/LO registers stay in mul_div_unit.

## Test plan
- MULTU A=0xFFFF_FFFF, B=0xFFFF_FFFF -> done exactly 33 cycles after the start edge; HI=0xFFFF_FFFE, LO=0x0000_0001.
- MULT A=-7 (0xFFFF_FFF9), B=6 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFD6; without MUL_DIV_SIGNED_EN -> HI=0x0000_0005, LO=0xFFFF_FFD6.
- DIV A=-17, B=5 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFE (-2); DIVU A=100, B=7 -> LO=14, HI=2.
- DIVU A=0x1234, B=0 -> LO=0xFFFF_FFFF, HI=0x1234 after full latency; DIV 0x8000_0000/-1 -> LO=0x8000_0000, HI=0.
- Start MULTU, a second start (DIVU) while busy, then MTLO while busy -> both ignored; only the MULTU result appears; done pulses once.
- Assert reset at cycle 10 of a DIV -> HI=LO=0 and busy=0 immediately; no done. Afterwards MTHI A=0xABCD -> out_hi_32=0xABCD next cycle, no busy, no done.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and iteration constants.
package mul_div_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic [4:0]  ITER_CNT  = 5'd31;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mul_div_if.sv
// Request/response bundle between execute-stage control and the mul/div unit.
interface mul_div_if;

  logic        in_start_1;
  logic [2:0]  in_op_3;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_busy_1;
  logic        out_done_1;
  logic [31:0] out_hi_32;
  logic [31:0] out_lo_32;

  modport master (
    output in_start_1, in_op_3, A, B,
    input  out_busy_1, out_done_1, out_hi_32, out_lo_32
  );

  modport slave (
    input  in_start_1, in_op_3, A, B,
    output out_busy_1, out_done_1, out_hi_32, out_lo_32
  );

endinterface

// File: rtl/mul_div_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring
// shift-subtract divide over a 64-bit {HI,LO} accumulator.
module mul_div_step
  import mul_div_pkg::*;
(
  input  logic        i_is_div,
  input  logic [63:0] i_acc,
  input  logic [31:0] i_opnd,
  output logic [63:0] o_acc
);

  logic [32:0] w_sum;
  logic [32:0] w_rem_sh;
  logic [33:0] w_trial;

  always_comb begin
    w_sum    = {1'b0, i_acc[63:32]} + (i_acc[0] ? {1'b0, i_opnd} : 33'd0);
    // 33-bit shifted remainder keeps the bit that would fall off the top
    w_rem_sh = i_acc[63:31];
    w_trial  = {1'b0, w_rem_sh} - {2'b00, i_opnd};
    if (i_is_div) begin
      if (w_trial[33]) o_acc = {w_rem_sh[31:0], i_acc[30:0], 1'b0};
      else             o_acc = {w_trial[31:0],  i_acc[30:0], 1'b1};
    end else begin
      o_acc = {w_sum, i_acc[31:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO.
// Signed MULT/DIV handling is built only when MUL_DIV_SIGNED_EN is defined.
module mul_div_unit
  import mul_div_pkg::*;
(
  input logic      clk,
  input logic      reset,
  mul_div_if.slave bus
);

  state_e      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic        r_is_div, r_div0, r_done;
  logic [31:0] r_hi, r_lo;
`ifdef MUL_DIV_SIGNED_EN
  logic        r_neg, r_neg_rem;
  logic        w_neg_a, w_neg_b;
`endif

  op_e         w_op;
  logic        w_idle_start, w_start_op, w_is_div;
  logic [31:0] w_abs_a, w_abs_b;
  logic [63:0] w_step, w_prod;
  logic [31:0] w_quot, w_rem;

  assign w_op         = op_e'(bus.in_op_3);
  assign w_idle_start = (r_state == IDLE) && bus.in_start_1;
  assign w_is_div     = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_start_op   = w_idle_start &&
                        (w_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});

  always_comb begin
    w_abs_a = bus.A;
    w_abs_b = bus.B;
`ifdef MUL_DIV_SIGNED_EN
    w_neg_a = ((w_op == OP_MULT) || (w_op == OP_DIV)) && bus.A[31];
    w_neg_b = ((w_op == OP_MULT) || (w_op == OP_DIV)) && bus.B[31];
    if (w_neg_a) w_abs_a = -bus.A;
    if (w_neg_b) w_abs_b = -bus.B;
`endif
  end

  mul_div_step u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step)
  );

  always_comb begin
    w_prod = r_acc;
    w_quot = r_acc[31:0];
    w_rem  = r_acc[63:32];
`ifdef MUL_DIV_SIGNED_EN
    if (r_neg) begin
      w_prod = -r_acc;
      w_quot = -r_acc[31:0];
    end
    if (r_neg_rem) w_rem = -r_acc[63:32];
`endif
    // Divide by zero leaves HI = dividend naturally; only the quotient is forced
    if (r_div0) w_quot = DIV0_QUOT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_op) w_next = RUN;
      RUN:     if (r_cnt == '0) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_is_div  <= 1'b0;
      r_div0    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
`ifdef MUL_DIV_SIGNED_EN
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_op) begin
            r_cnt    <= ITER_CNT;
            r_is_div <= w_is_div;
            r_div0   <= w_is_div && (bus.B == '0);
            r_acc    <= {32'd0, (w_is_div ? w_abs_a : w_abs_b)};
            r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
`ifdef MUL_DIV_SIGNED_EN
            r_neg     <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
`endif
          end else if (w_idle_start && (w_op == OP_MTHI)) begin
            r_hi <= bus.A;
          end else if (w_idle_start && (w_op == OP_MTLO)) begin
            r_lo <= bus.A;
          end
        end
        RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - 5'd1;
        end
        FIX: begin
          r_hi   <= r_is_div ? w_rem  : w_prod[63:32];
          r_lo   <= r_is_div ? w_quot : w_prod[31:0];
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_busy_1 = (r_state != IDLE);
  assign bus.out_done_1 = r_done;
  assign bus.out_hi_32  = r_hi;
  assign bus.out_lo_32  = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  logic clk = 1'b0;
  logic reset;
  mul_div_if bus();

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned due;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
  // the remainder follows the dividend, matching the required semantics.
  function automatic logic [63:0] model(input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    bit          sgn = 1'b0;
    longint      sa, sb, q, r;
    logic [63:0] p;
`ifdef MUL_DIV_SIGNED_EN
    sgn = (op == OP_MULT) || (op == OP_DIV);
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (op == OP_MULT || op == OP_MULTU) begin
      p = sa * sb;
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns one negedge later with start dropped.
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit expect_run, input string tag);
    logic [63:0] r;
    bus.in_start_1 = 1'b1;
    bus.in_op_3    = op;
    bus.A          = a;
    bus.B          = b;
    if (expect_run) begin
      r = model(op, a, b);
      sbq.push_back('{hi: r[63:32], lo: r[31:0], due: cyc + 34, tag: tag});
      m_hi = r[63:32];
      m_lo = r[31:0];
    end
    @(negedge clk);
    bus.in_start_1 = 1'b0;
    bus.A          = $urandom;
    bus.B          = $urandom;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    issue(op, a, b, 1'b1, tag);
    repeat (33) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && bus.out_done_1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk({e.tag, "_hi"}, 64'(bus.out_hi_32), 64'(e.hi));
        chk({e.tag, "_lo"}, 64'(bus.out_lo_32), 64'(e.lo));
        chk({e.tag, "_latency"}, 64'(cyc), 64'(e.due));
        chk({e.tag, "_busy_at_done"}, 64'(bus.out_busy_1), 64'd0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : stim
    logic [2:0]  op;
    logic [31:0] a, b;

    reset          = 1'b0;
    bus.in_start_1 = 1'b0;
    bus.in_op_3    = '0;
    bus.A          = '0;
    bus.B          = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.out_busy_1), 64'd0);
    chk("rst_done", 64'(bus.out_done_1), 64'd0);
    chk("rst_hi",   64'(bus.out_hi_32),  64'd0);
    chk("rst_lo",   64'(bus.out_lo_32),  64'd0);
    reset = 1'b1;
    @(negedge clk);

    // MULTU max*max with busy observed through the FIX cycle
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu_max");
    chk("busy_running", 64'(bus.out_busy_1), 64'd1);
    repeat (32) @(negedge clk);
    chk("busy_fix_cycle", 64'(bus.out_busy_1), 64'd1);
    @(negedge clk);

    run_op(OP_MULT, 32'hFFFF_FFF9, 32'd6, "mult_neg7x6");
    run_op(OP_DIV,  32'hFFFF_FFEF, 32'd5, "div_neg17by5");
    run_op(OP_DIVU, 32'd100, 32'd7, "divu_100by7");
    run_op(OP_DIVU, 32'h0000_1234, 32'd0, "divu_by0");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(OP_DIV,  32'hFFFF_FFF0, 32'd0, "div_neg_by0");

    // Starts while busy are ignored, including MTLO
    issue(OP_MULTU, 32'd12345, 32'd678, 1'b1, "multu_busy");
    repeat (4) @(negedge clk);
    chk("busy_mid", 64'(bus.out_busy_1), 64'd1);
    issue(OP_DIVU, 32'd99, 32'd3, 1'b0, "ign_divu");
    issue(OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0, "ign_mtlo");
    repeat (27) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("busy_ignore_lo", 64'(bus.out_lo_32), 64'(m_lo));

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = rnd_opnd();
      b  = rnd_opnd();
      if (op <= 3'd3) begin
        run_op(op, a, b, "rnd");
      end else if (op == 3'd4 || op == 3'd5) begin
        issue(op, a, b, 1'b0, "mt");
        if (op == 3'd4) m_hi = a;
        else            m_lo = a;
        chk("rnd_mt_busy", 64'(bus.out_busy_1), 64'd0);
        chk("rnd_mt_hi", 64'(bus.out_hi_32), 64'(m_hi));
        chk("rnd_mt_lo", 64'(bus.out_lo_32), 64'(m_lo));
      end else begin
        issue(op, a, b, 1'b0, "nop");
        chk("rnd_nop_busy", 64'(bus.out_busy_1), 64'd0);
        chk("rnd_nop_hi", 64'(bus.out_hi_32), 64'(m_hi));
        chk("rnd_nop_lo", 64'(bus.out_lo_32), 64'(m_lo));
      end
    end

    // Make HI/LO nonzero so the reset clear is observable
    run_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, "pre_reset");
    issue(OP_DIV, 32'hFFFF_FF00, 32'd7, 1'b1, "div_reset");
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.out_busy_1), 64'd0);
    chk("midrst_done", 64'(bus.out_done_1), 64'd0);
    chk("midrst_hi",   64'(bus.out_hi_32),  64'd0);
    chk("midrst_lo",   64'(bus.out_lo_32),  64'd0);
    sbq.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    issue(OP_MTHI, 32'h0000_ABCD, 32'd0, 1'b0, "mthi");
    chk("mthi_hi",   64'(bus.out_hi_32),  64'h0000_ABCD);
    chk("mthi_lo",   64'(bus.out_lo_32),  64'd0);
    chk("mthi_busy", 64'(bus.out_busy_1), 64'd0);
    chk("mthi_done", 64'(bus.out_done_1), 64'd0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
